// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state type and counter sizing for the scanned button debouncer
package debounce_pkg;
    typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} btn_state_t;
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction
endpackage

// File: rtl/debounce_tick_gen.sv
// debounce_tick_gen: free-running sampling tick divider, held at zero while disabled
module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_o
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);
    logic [TW-1:0] count;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else count <= (!en || count == LAST) ? '0 : count + 1'b1;
    assign tick_o = en && count == LAST;
endmodule

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: one shared debounce engine walked across all buttons after each tick
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] db_out,
    output logic [N_BTN-1:0] press,
    // release is a reserved word, hence the suffix
    output logic [N_BTN-1:0] release_o,
    output logic             tick_o,
    output logic             scan_busy,
    output logic             overrun
);
    localparam int CW = cnt_width(STABLE_TICKS);
    localparam int IW = N_BTN > 1 ? $clog2(N_BTN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_BTN - 1);
    localparam logic [CW-1:0] DONE = CW'(STABLE_TICKS);
    logic [N_BTN-1:0] sync1, sync2, snap;
    logic [IW-1:0] idx;
    btn_state_t state [N_BTN];
    logic [CW-1:0] cnt [N_BTN];
    btn_state_t next_state;
    logic [CW-1:0] next_cnt, cnt_inc;
    logic s, rise_hit, fall_hit;

    debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk, .rst, .en, .tick_o);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            snap      <= '0;
            idx       <= '0;
            scan_busy <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            if (tick_o && !scan_busy) begin
                snap      <= sync2;
                idx       <= '0;
                scan_busy <= 1'b1;
            end else if (scan_busy) begin
                idx       <= idx + 1'b1;
                scan_busy <= idx != LAST_IDX;
            end
            if (tick_o && scan_busy) overrun <= 1'b1;
        end

    // Next state for whichever button owns the current slot
    always_comb begin
        s          = snap[idx];
        cnt_inc    = cnt[idx] + 1'b1;
        next_state = state[idx];
        next_cnt   = cnt[idx];
        rise_hit   = 1'b0;
        fall_hit   = 1'b0;
        case (state[idx])
            LOW:  if (s) begin next_state = RISE; next_cnt = CW'(1); end
            RISE: if (!s) begin next_state = LOW; next_cnt = '0; end
                  else if (cnt_inc == DONE) begin next_state = HIGH; next_cnt = '0; rise_hit = 1'b1; end
                  else next_cnt = cnt_inc;
            HIGH: if (!s) begin next_state = FALL; next_cnt = CW'(1); end
            FALL: if (s) begin next_state = HIGH; next_cnt = '0; end
                  else if (cnt_inc == DONE) begin next_state = LOW; next_cnt = '0; fall_hit = 1'b1; end
                  else next_cnt = cnt_inc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= LOW;
                cnt[i]   <= '0;
            end
            db_out    <= '0;
            press     <= '0;
            release_o <= '0;
        end else begin
            press     <= '0;
            release_o <= '0;
            if (scan_busy) begin
                state[idx]     <= next_state;
                cnt[idx]       <= next_cnt;
                press[idx]     <= rise_hit;
                release_o[idx] <= fall_hit;
                if (rise_hit || fall_hit) db_out[idx] <= rise_hit;
            end
        end
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl: vector table plus cycle-exact strobe scoreboard for the scanned debouncer
module tb_debounce_scan_ctrl;
    localparam int N = 4, TD = 8, ST = 3, NV = 28;
    typedef struct {logic [3:0] btn; logic [3:0] db;} vec_t;
    typedef struct {int c; int b; logic l; logic p; logic r;} ev_t;
    logic clk = 0, rst = 1, en = 1;
    logic [3:0] btn_in = 0, db_out, press, release_o;
    logic [3:0] btn3 = 0, db3, press3, rel3;
    logic tick_o, scan_busy, overrun, tick3, busy3, ovr3;
    int checks = 0, failures = 0, cyc = 0, k = 0, last_t = -100;
    logic [3:0] prev = 0, smp = 0, edb = 0, lvl = 0;
    logic eovr = 0, tick_now = 0;
    int run [4];
    ev_t q[$];
    vec_t tab [NV];

    always #5 clk = ~clk;

    debounce_scan_ctrl #(.N_BTN(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .en(en), .btn_in(btn_in), .db_out(db_out), .press(press),
        .release_o(release_o), .tick_o(tick_o), .scan_busy(scan_busy), .overrun(overrun));

    debounce_scan_ctrl #(.N_BTN(N), .TICK_DIV(3), .STABLE_TICKS(ST)) dut3 (
        .clk(clk), .rst(rst), .en(1'b1), .btn_in(btn3), .db_out(db3), .press(press3),
        .release_o(rel3), .tick_o(tick3), .scan_busy(busy3), .overrun(ovr3));

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    // One clock: predict this cycle's outputs, compare, then advance the debounce model
    task automatic step();
        logic [3:0] ep, er;
        logic et, eb;
        ev_t e;
        @(negedge clk);
        cyc++;
        smp = prev;
        prev = btn_in;
        tick_now = 0;
        if (rst) begin
            k = 0; last_t = -100; q.delete(); edb = 0; lvl = 0; eovr = 0;
            foreach (run[i]) run[i] = 0;
        end else k = !en ? 0 : (k == TD - 1 ? 0 : k + 1);
        et = !rst && en && k == TD - 1;
        eb = cyc > last_t && cyc <= last_t + N;
        ep = 0;
        er = 0;
        while (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            edb[e.b] = e.l;
            ep[e.b] = e.p;
            er[e.b] = e.r;
        end
        chk("tick_o", 4'(tick_o), 4'(et));
        chk("scan_busy", 4'(scan_busy), 4'(eb));
        chk("press", press, ep);
        chk("release", release_o, er);
        chk("db_out", db_out, edb);
        chk("overrun", 4'(overrun), 4'(eovr));
        if (et && eb) eovr = 1;
        if (et && !eb) begin
            last_t = cyc;
            tick_now = 1;
            for (int i = 0; i < N; i++) begin
                e = '{c: cyc + 2 + i, b: i, l: 1'b0, p: 1'b0, r: 1'b0};
                run[i] = (smp[i] != lvl[i]) ? run[i] + 1 : 0;
                if (run[i] == ST) begin
                    lvl[i] = smp[i];
                    run[i] = 0;
                    e.p = smp[i];
                    e.r = !smp[i];
                end
                e.l = lvl[i];
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 3 * TD; n++) begin
            step();
            if (tick_now) return;
        end
        checks++;
        failures++;
        $display("FAIL tick_timeout cycle=%0d actual=none required=tick", cyc);
    endtask

    initial begin
        tab = '{'{4'h0, 4'h0}, '{4'h0, 4'h0}, '{4'h0, 4'h0}, '{4'h0, 4'h0}, '{4'h0, 4'h0},
                '{4'h1, 4'h0}, '{4'h1, 4'h0}, '{4'h1, 4'h1},
                '{4'h3, 4'h1}, '{4'h3, 4'h1}, '{4'h1, 4'h1}, '{4'h3, 4'h1}, '{4'h3, 4'h1}, '{4'h3, 4'h3},
                '{4'h2, 4'h3}, '{4'h3, 4'h3}, '{4'h2, 4'h3}, '{4'h2, 4'h3}, '{4'h2, 4'h2},
                '{4'h0, 4'h2}, '{4'h0, 4'h2}, '{4'h0, 4'h0},
                '{4'h9, 4'h0}, '{4'h9, 4'h0}, '{4'h9, 4'h9},
                '{4'h0, 4'h9}, '{4'h0, 4'h9}, '{4'h0, 4'h0}};
        btn_in = 4'($urandom);
        repeat (3) step();
        rst = 0;
        btn_in = tab[0].btn;
        for (int r = 0; r < NV; r++) begin
            wait_tick();
            btn_in = r + 1 < NV ? tab[r + 1].btn : 4'h0;
            repeat (N + 2) step();
            chk($sformatf("vec%0d_db", r), db_out, tab[r].db);
        end
        // Disable mid-scan: the scan finishes, then no ticks
        wait_tick();
        step();
        en = 0;
        repeat (20) step();
        en = 1;
        // Reset lands on the cycle a press strobe is showing
        wait_tick();
        btn_in = 4'h1;
        repeat (3) wait_tick();
        repeat (2) step();
        chk("press_pre_rst", press, 4'h1);
        rst = 1;
        #1;
        chk("rst_db", db_out, 4'h0);
        chk("rst_press", press, 4'h0);
        chk("rst_release", release_o, 4'h0);
        chk("rst_busy", 4'(scan_busy), 4'h0);
        chk("rst_tick", 4'(tick_o), 4'h0);
        repeat (2) step();
        rst = 0;
        repeat (12) step();
        // Fast divider: second tick lands inside the first scan
        rst = 1;
        step();
        rst = 0;
        for (int j = 1; j <= 30; j++) begin
            step();
            chk("ovr3_tick", 4'(tick3), 4'(j % 3 == 2));
            chk("ovr3_busy", 4'(busy3), 4'(j >= 3 && (j - 3) % 6 < 4));
            chk("ovr3_overrun", 4'(ovr3), 4'(j >= 6));
            chk("ovr3_quiet", press3 | rel3 | db3, 4'h0);
        end
        rst = 1;
        #1;
        chk("ovr3_rst", 4'(ovr3), 4'h0);
        chk("overrun_rst", 4'(overrun), 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
- Generates the debounce sampling tick for all front-panel buttons.
- Time-multiplexes one shared debounce engine across N_BTN buttons: one button per clock after each tick.
- Produces clean levels plus one-cycle press/release strobes for the 7-seg counter logic.
- Sits between the raw board buttons and the counter/display control.

Parameters:
- N_BTN, 4, number of buttons scanned.
- TICK_DIV, 100000, clk cycles per sampling tick (1 ms at 100 MHz); must be >= 2.
- STABLE_TICKS, 10, consecutive equal samples required to change the debounced level; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enables tick generation.
- btn_in  in  N_BTN  raw asynchronous button inputs.
- db_out  out  N_BTN  debounced levels.
- press  out  N_BTN  one-cycle strobe on debounced 0->1.
- release  out  N_BTN  one-cycle strobe on debounced 1->0.
- tick_o  out  1  one-cycle sampling tick.
- scan_busy  out  1  high while the engine is walking buttons.
- overrun  out  1  sticky: a tick arrived during a scan.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0. All per-button states are LOW with count 0. Synchronizers, snapshot, tick counter and scan index are 0. Reset applies immediately, including mid-scan; the scan in progress is abandoned.
- Input sync: each btn_in bit passes through a 2-FF synchronizer.
- Tick counter:
  - While en=1, counts 0..TICK_DIV-1 and wraps to 0.
  - tick_o=1 for exactly the cycle in which count==TICK_DIV-1.
  - en=0 holds the count at 0 and produces no ticks. A scan already in progress completes.
- Tick accepted (cycle T, tick_o=1 and scan_busy=0):
  - The synchronized inputs are captured into a snapshot.
  - scan_busy=1 from T+1 through T+N_BTN; scan index i=0.
  - Slot for button i is cycle T+1+i.
- Tick during scan (tick_o=1 and scan_busy=1): the tick is dropped, the snapshot is unchanged, and overrun is set. overrun clears only on rst.
- Per-button FSM, one update per slot, sample s = snapshot[i], count cnt:
  - LOW: s=1 -> RISE, cnt=1. s=0 -> stay.
  - RISE: s=1 and cnt+1==STABLE_TICKS -> HIGH, cnt=0, db_out=1, press=1. s=1 otherwise -> cnt+1. s=0 -> LOW, cnt=0 (bounce discarded).
  - HIGH: s=0 -> FALL, cnt=1. s=1 -> stay.
  - FALL: s=0 and cnt+1==STABLE_TICKS -> LOW, cnt=0, db_out=0, release=1. s=0 otherwise -> cnt+1. s=1 -> HIGH, cnt=0.
- Output timing:
  - db_out[i] updates, and press[i]/release[i] pulse, in cycle T+2+i.
  - Strobes are exactly one cycle wide.
  - Worst latency from a stable synchronized edge is STABLE_TICKS ticks plus N_BTN+1 cycles.
- Width: cnt is clog2(STABLE_TICKS+1) bits and never exceeds STABLE_TICKS-1 in stored state.
- Buttons not in their slot hold their state and outputs; strobes for idle buttons are 0.
- Simultaneous edges on several buttons produce strobes staggered by slot order, never merged.

Decomposition:
- Shared package debounce_pkg:
  - btn_state_t enum: LOW, RISE, HIGH, FALL.
  - clog2-based count-width function.
- Sub-module debounce_tick_gen: counter, en gating and tick_o.
- The scanner, state/count register array and output strobes stay in debounce_scan_ctrl.

Test Plan (bench parameters N_BTN=4, TICK_DIV=8, STABLE_TICKS=3 unless noted):
1. Reset: rst=1 with random btn_in, then release; hold btn_in=0 for 5 ticks -> all outputs stay 0. tick_o period is 8 cycles. scan_busy is high 4 cycles after each tick.
2. Clean press: btn_in[0]=1 held. The third tick sampling 1 at cycle T gives press[0]=1 only at T+2 and db_out[0]=1 from T+2. No other strobes.
3. Bounce: btn_in[1] samples 1,1,0,1,1,1 over 6 ticks. Exactly one press[1], at slot after the 6th tick (cycle T6+3). db_out[1]=0 before then.
4. Release: after scenario 2, btn_in[0]=0. Third tick sampling 0 gives release[0] single pulse at T+2 and db_out[0]=0. A single-tick glitch back to 1 during FALL returns to HIGH with no strobe.
5. Simultaneous: btn_in[0] and btn_in[3] rise together. press[0] at T+2, press[3] at T+5 of the same tick.
6. Reset and overrun:
   - rst asserted at cycle T+2 of a scan -> all outputs 0 immediately.
   - Rerun with TICK_DIV=3 -> overrun goes high on the first tick during a scan and stays high until rst.
